mu0_multicycle_sequencer: RTL and testbench
===========================================

// Module: mu0_multicycle_sequencer
// PURPOSE
//   Registered, parametrised sequencer for MU0 multi-cycle instructions (linked-list walk,
//   random-state, FBCV and further extension modes). Replaces hand-written per-mode next-state
//   equations with a one-hot mode decoder, a per-mode programmable execute length, an 'extra'
//   cycle extension, a pipeline stall and a done/error handshake back to the MU0 control unit.
// PARAMETERS
//   NUM_MODES  3  number of one-hot mode select lines (bit0=LINKED_LIST, bit1=RND, bit2=FBCV)
//   CYCLE_W    4  width of per-mode execute length and cycle counter
//   STATE_W    3  width of exported state code (>=3)
// PORTS
//   clk        in   1                  system clock, all state updates on rising edge
//   rst_n      in   1                  synchronous active-low reset
//   start      in   1                  control unit requests a multi-cycle sequence
//   mode_sel   in   NUM_MODES          one-hot mode request, sampled in DECODE only
//   mode_len   in   NUM_MODES*CYCLE_W  execute length per mode, slice i = mode i
//   extra      in   1                  hold/extend: while 1 in EXEC, sequence does not finish
//   stall      in   1                  freeze: no state, counter or output change this cycle
//   state      out  STATE_W            current state code
//   mode_q     out  NUM_MODES          mode latched in DECODE (0 = no mode)
//   cnt        out  CYCLE_W            remaining execute cycles
//   busy       out  1                  1 in any state other than IDLE
//   done       out  1                  one-cycle pulse, sequence completed
//   err        out  1                  one-cycle pulse, illegal mode_sel (>1 bit set)
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, mode_q=0, cnt=0, busy=0, done=0, err=0. Wins over all
//     inputs including stall; reset mid-sequence aborts with no done/err pulse.
//   State codes: IDLE=0, DECODE=1, EXEC=2, FINISH=3; codes 4..7 unreachable, decode to IDLE.
//   stall=1: every register holds; done/err hold their current value (pulse lengthens).
//   IDLE:   start=1 -> DECODE; start=0 -> IDLE. start ignored in all other states.
//   DECODE: popcount(mode_sel)>1 -> IDLE, err=1 next cycle, mode_q=0.
//           popcount==1 -> EXEC, mode_q=mode_sel, cnt=max(mode_len[slice],1)-1.
//           popcount==0 & extra=1 -> EXEC, mode_q=0, cnt=0.
//           popcount==0 & extra=0 -> FINISH (plain single-pass instruction).
//   EXEC:   cnt!=0 -> cnt decrements by 1, stay EXEC (extra irrelevant).
//           cnt==0 & extra=1 -> stay EXEC, cnt stays 0.
//           cnt==0 & extra=0 -> FINISH.
//   FINISH: done=1 for this cycle only; -> IDLE; mode_q cleared on exit.
//   done is asserted while state==FINISH (registered, no combinational path from inputs).
//   Latency (no stall, extra=0, popcount==1, len L>=1): start high at edge k -> DECODE k+1,
//     EXEC k+2..k+1+L, done=1 in cycle k+2+L; busy high k+1..k+2+L. len 0 behaves as len 1.
//   Counter never wraps: decrement only when cnt!=0.
//   busy = (state!=IDLE). mode_sel/mode_len changes outside DECODE have no effect.
// TESTING
//   1 Reset: rst_n=0 2 cycles with start=1,stall=1 -> state=0,busy=0,done=0,err=0,cnt=0.
//   2 Mode RND, mode_len slice1=3, start 1 cycle -> states 1,2,2,2,3,0; done high exactly 1 cycle,
//     cnt 2,1,0; mode_q=3'b010 during EXEC/FINISH.
//   3 mode_sel=3'b101 in DECODE -> err=1 one cycle, return to IDLE, done never set, mode_q=0.
//   4 Mode LINKED_LIST len=1, extra held 4 cycles after cnt hits 0 -> EXEC lasts 5 cycles,
//     FINISH follows the cycle after extra drops; also mode_sel=0,extra=0 -> 1,3,0.
//   5 stall=1 for 3 cycles mid-EXEC (cnt=2) and during FINISH -> cnt frozen at 2, total latency
//     +3; done held high across stalled FINISH cycles, then one more cycle, then IDLE.
//   6 rst_n=0 for one cycle while state=EXEC, cnt=5 -> next cycle IDLE, no done/err; new start
//     afterwards runs a full normal sequence.

Source files
------------

// File: rtl/mu0_multicycle_sequencer.sv
// MU0 multi-cycle instruction sequencer: one-hot mode decode, per-mode
// execute length, extra-cycle hold, stall freeze and done/err handshake.
module mu0_multicycle_sequencer #(
    parameter int NUM_MODES = 3,
    parameter int CYCLE_W   = 4,
    parameter int STATE_W   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_MODES-1:0]           mode_sel,
    input  logic [NUM_MODES*CYCLE_W-1:0]   mode_len,
    input  logic                           extra,
    input  logic                           stall,
    output logic [STATE_W-1:0]             state,
    output logic [NUM_MODES-1:0]           mode_q,
    output logic [CYCLE_W-1:0]             cnt,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    typedef enum logic [STATE_W-1:0] {
        IDLE   = STATE_W'(0),
        DECODE = STATE_W'(1),
        EXEC   = STATE_W'(2),
        FINISH = STATE_W'(3)
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [NUM_MODES-1:0] mode_d;
    logic [CYCLE_W-1:0]   cnt_q;
    logic [CYCLE_W-1:0]   cnt_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic                 err_q;
    logic                 err_d;

    logic                 sel_none;
    logic                 sel_multi;
    logic [CYCLE_W-1:0]   sel_len;
    logic [CYCLE_W-1:0]   sel_load;

    // Classify mode_sel (none / one / several) and pick the selected length
    always_comb begin
        sel_none  = 1'b1;
        sel_multi = 1'b0;
        sel_len   = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_sel[i]) begin
                if (!sel_none) begin
                    sel_multi = 1'b1;
                end
                sel_none = 1'b0;
                sel_len  = sel_len | mode_len[i*CYCLE_W +: CYCLE_W];
            end
        end
    end

    // A zero length runs as a single execute cycle
    assign sel_load = (sel_len == '0) ? '0 : (sel_len - CYCLE_W'(1));

    // Next-state, counter and mode-latch logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (sel_multi) begin
                    state_d = IDLE;
                    mode_d  = '0;
                    err_d   = 1'b1;
                end else if (!sel_none) begin
                    state_d = EXEC;
                    mode_d  = mode_sel;
                    cnt_d   = sel_load;
                end else if (extra) begin
                    state_d = EXEC;
                    mode_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = FINISH;
                    mode_d  = '0;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CYCLE_W'(1);
                end else if (!extra) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                mode_d  = '0;
            end
            default: begin
                state_d = IDLE;
                mode_d  = '0;
                cnt_d   = '0;
            end
        endcase
        done_d = (state_d == FINISH);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset beats stall, stall freezes all
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign state = state_q;
    assign cnt   = cnt_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mu0_multicycle_sequencer.sv
// Directed bench for mu0_multicycle_sequencer: per-cycle expected
// outputs are queued with each stimulus step and checked after the edge.
module tb_mu0_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode_sel;
    logic [11:0] mode_len;
    logic        extra;
    logic        stall;
    logic [2:0]  state;
    logic [2:0]  mode_q;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] md;
        logic [3:0] cn;
        logic       bz;
        logic       dn;
        logic       er;
    } obs_t;

    obs_t exp_q[$];

    mu0_multicycle_sequencer #(
        .NUM_MODES(3),
        .CYCLE_W  (4),
        .STATE_W  (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode_sel(mode_sel),
        .mode_len(mode_len),
        .extra   (extra),
        .stall   (stall),
        .state   (state),
        .mode_q  (mode_q),
        .cnt     (cnt),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Queue the expected post-edge outputs, clock once, then compare
    task automatic step(input logic [2:0] st, input logic [2:0] md,
                        input logic [3:0] cn, input logic dn,
                        input logic er, input string tag);
        obs_t e;
        obs_t o;
        e.st = st;
        e.md = md;
        e.cn = cn;
        e.bz = (st != 3'd0);
        e.dn = dn;
        e.er = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = {state, mode_q, cnt, busy, done, err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: got st=%0d md=%b cnt=%0d busy=%b done=%b err=%b, expected st=%0d md=%b cnt=%0d busy=%b done=%b err=%b",
                       tag, o.st, o.md, o.cn, o.bz, o.dn, o.er,
                       e.st, e.md, e.cn, e.bz, e.dn, e.er);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        stall    = 1'b1;
        extra    = 1'b0;
        mode_sel = 3'b000;
        mode_len = 12'h000;

        // Reset beats start and stall
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "reset0");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "reset1");
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "idle");
        // Stall in IDLE swallows start
        stall = 1'b1;
        start = 1'b1;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "stall_idle");
        stall = 1'b0;
        start = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "idle_nostart");

        // RND, length 3
        mode_sel = 3'b010;
        mode_len = 12'h030;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "rnd_decode");
        start    = 1'b0;
        step(3'd2, 3'b010, 4'd2, 1'b0, 1'b0, "rnd_exec2");
        mode_sel = 3'b001;
        mode_len = 12'hFFF;
        start    = 1'b1;
        step(3'd2, 3'b010, 4'd1, 1'b0, 1'b0, "rnd_exec1");
        step(3'd2, 3'b010, 4'd0, 1'b0, 1'b0, "rnd_exec0");
        step(3'd3, 3'b010, 4'd0, 1'b1, 1'b0, "rnd_finish");
        start    = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "rnd_idle");

        // Illegal one-hot
        mode_sel = 3'b101;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "ill_decode");
        start    = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b1, "ill_err");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "ill_err_drop");
        // Stall stretches the err pulse
        mode_sel = 3'b011;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "ill2_decode");
        start    = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b1, "ill2_err");
        stall    = 1'b1;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b1, "ill2_err_held");
        stall    = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "ill2_err_drop");

        // LINKED_LIST len 1 with extra held 4 cycles
        mode_sel = 3'b001;
        mode_len = 12'h001;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "ll_decode");
        start    = 1'b0;
        step(3'd2, 3'b001, 4'd0, 1'b0, 1'b0, "ll_exec1");
        extra    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(3'd2, 3'b001, 4'd0, 1'b0, 1'b0, "ll_exec_extra");
        end
        extra    = 1'b0;
        step(3'd3, 3'b001, 4'd0, 1'b1, 1'b0, "ll_finish");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "ll_idle");

        // Plain single-pass instruction
        mode_sel = 3'b000;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "plain_decode");
        start    = 1'b0;
        step(3'd3, 3'b000, 4'd0, 1'b1, 1'b0, "plain_finish");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "plain_idle");

        // No mode but extra: modeless execute
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "nomode_decode");
        start    = 1'b0;
        extra    = 1'b1;
        step(3'd2, 3'b000, 4'd0, 1'b0, 1'b0, "nomode_exec");
        extra    = 1'b0;
        step(3'd3, 3'b000, 4'd0, 1'b1, 1'b0, "nomode_finish");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "nomode_idle");

        // Length 0 behaves as length 1
        mode_sel = 3'b001;
        mode_len = 12'h000;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "len0_decode");
        start    = 1'b0;
        step(3'd2, 3'b001, 4'd0, 1'b0, 1'b0, "len0_exec");
        step(3'd3, 3'b001, 4'd0, 1'b1, 1'b0, "len0_finish");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "len0_idle");

        // FBCV len 3 with stalls in EXEC and FINISH
        mode_sel = 3'b100;
        mode_len = 12'h300;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "stl_decode");
        start    = 1'b0;
        step(3'd2, 3'b100, 4'd2, 1'b0, 1'b0, "stl_exec2");
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(3'd2, 3'b100, 4'd2, 1'b0, 1'b0, "stl_frozen");
        end
        stall    = 1'b0;
        step(3'd2, 3'b100, 4'd1, 1'b0, 1'b0, "stl_exec1");
        step(3'd2, 3'b100, 4'd0, 1'b0, 1'b0, "stl_exec0");
        step(3'd3, 3'b100, 4'd0, 1'b1, 1'b0, "stl_finish");
        stall    = 1'b1;
        step(3'd3, 3'b100, 4'd0, 1'b1, 1'b0, "stl_finish_h1");
        step(3'd3, 3'b100, 4'd0, 1'b1, 1'b0, "stl_finish_h2");
        stall    = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "stl_idle");

        // Reset mid-EXEC aborts silently
        mode_sel = 3'b010;
        mode_len = 12'h060;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "abt_decode");
        start    = 1'b0;
        step(3'd2, 3'b010, 4'd5, 1'b0, 1'b0, "abt_exec5");
        rst_n    = 1'b0;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "abt_reset");
        rst_n    = 1'b1;
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "abt_idle");
        mode_sel = 3'b001;
        mode_len = 12'h002;
        start    = 1'b1;
        step(3'd1, 3'b000, 4'd0, 1'b0, 1'b0, "re_decode");
        start    = 1'b0;
        step(3'd2, 3'b001, 4'd1, 1'b0, 1'b0, "re_exec1");
        step(3'd2, 3'b001, 4'd0, 1'b0, 1'b0, "re_exec0");
        step(3'd3, 3'b001, 4'd0, 1'b1, 1'b0, "re_finish");
        step(3'd0, 3'b000, 4'd0, 1'b0, 1'b0, "re_idle");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d left, expected 0",
                   exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
